// File: rtl/npc_pkg.sv
// npc_pkg: shared state encoding, SYSTEM/ebreak opcode constants and default
// counter width for the NPC control sequencer.
package npc_pkg;

   localparam int          CNT_W_DEF      = 64;
   localparam logic [6:0]  OPC_SYSTEM     = 7'b1110011;
   localparam logic [11:0] FUNCT12_EBREAK = 12'h001;

   typedef enum logic [2:0] {
      ST_FETCH_REQ  = 3'd0,
      ST_FETCH_WAIT = 3'd1,
      ST_DECODE     = 3'd2,
      ST_MEM_REQ    = 3'd3,
      ST_MEM_WAIT   = 3'd4,
      ST_COMMIT     = 3'd5,
      ST_HALT       = 3'd6
   } npc_state_e;

   // ebreak is the SYSTEM opcode with funct12=1 and rs1/funct3/rd all zero
   function automatic logic is_ebreak(input logic [31:0] inst);
      return (inst[6:0] == OPC_SYSTEM) && (inst[31:20] == FUNCT12_EBREAK) &&
             (inst[19:7] == 13'd0);
   endfunction

endpackage

// File: rtl/npc_perf_cnt.sv
// npc_perf_cnt: retired-instruction and free-running cycle counters for the
// simulation environment; both wrap silently.
module npc_perf_cnt
   import npc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             retire,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_cnt  <= '0;
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_ONE;
         if (retire) begin
            inst_cnt <= inst_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/npc_ctrl.sv
// npc_ctrl: multi-cycle fetch/decode/mem/commit sequencer for the NPC core.
// Optional handshake watchdog enabled by defining NPC_CTRL_TIMEOUT_EN.
//
// state      | meaning
// FETCH_REQ  | instruction request raised, waiting for imem_req_ready
// FETCH_WAIT | request accepted, waiting for the instruction word
// DECODE     | one cycle; pick HALT / MEM_REQ / COMMIT
// MEM_REQ    | data request raised, waiting for lsu_req_ready
// MEM_WAIT   | data request accepted, waiting for completion
// COMMIT     | one cycle; update PC, write RF, retire
// HALT       | ebreak or watchdog; terminal until reset
module npc_ctrl
   import npc_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   input  logic             imem_rsp_valid,
   output logic             ir_we,
   input  logic             dec_regwrite,
   input  logic             dec_is_mem,
   input  logic             dec_is_ebreak,
   output logic             lsu_req_valid,
   input  logic             lsu_req_ready,
   input  logic             lsu_rsp_valid,
   output logic             rf_we,
   output logic             pc_we,
   output logic             halted,
   output logic             err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   npc_state_e state_q;
   npc_state_e state_d;
   logic       retire;
   logic       wd_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      imem_req_valid = 1'b0;
      ir_we          = 1'b0;
      lsu_req_valid  = 1'b0;
      pc_we          = 1'b0;
      rf_we          = 1'b0;
      retire         = 1'b0;
      case (state_q)
         ST_FETCH_REQ: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
               if (imem_rsp_valid) begin
                  ir_we   = 1'b1;
                  state_d = ST_DECODE;
               end else begin
                  state_d = ST_FETCH_WAIT;
               end
            end
         end
         ST_FETCH_WAIT: begin
            if (imem_rsp_valid) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_is_ebreak) begin
               state_d = ST_HALT;
            end else if (dec_is_mem) begin
               state_d = ST_MEM_REQ;
            end else begin
               state_d = ST_COMMIT;
            end
         end
         ST_MEM_REQ: begin
            lsu_req_valid = 1'b1;
            if (lsu_req_ready) begin
               state_d = lsu_rsp_valid ? ST_COMMIT : ST_MEM_WAIT;
            end
         end
         ST_MEM_WAIT: begin
            if (lsu_rsp_valid) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            pc_we   = 1'b1;
            rf_we   = dec_regwrite;
            retire  = 1'b1;
            state_d = ST_FETCH_REQ;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH_REQ;
         end
      endcase
      if (wd_fire) begin
         state_d = ST_HALT;
      end
      // Outputs are Moore-style, so a reset landing mid-handshake must mask them
      if (rst) begin
         imem_req_valid = 1'b0;
         ir_we          = 1'b0;
         lsu_req_valid  = 1'b0;
         pc_we          = 1'b0;
         rf_we          = 1'b0;
         retire         = 1'b0;
      end
   end

`ifdef NPC_CTRL_TIMEOUT_EN
   localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   logic [WD_W-1:0] wd_q;
   logic            in_wait;
   logic            err_q;

   assign in_wait = (state_q == ST_FETCH_REQ) || (state_q == ST_FETCH_WAIT) ||
                    (state_q == ST_MEM_REQ)   || (state_q == ST_MEM_WAIT);
   // Down-counter reloads on any state change; terminal count on the last stalled cycle
   assign wd_fire = in_wait && (wd_q == '0) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= WD_LOAD;
         err_q <= 1'b0;
      end else begin
         if (state_d != state_q) begin
            wd_q <= WD_LOAD;
         end else if (in_wait) begin
            wd_q <= wd_q - WD_ONE;
         end
         if (wd_fire) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT_CYC > 0);
   assign wd_fire        = 1'b0;
   assign err            = 1'b0;
`endif

   assign halted = (state_q == ST_HALT);
   assign state  = state_q;

   npc_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk       (clk),
      .rst       (rst),
      .retire    (retire),
      .inst_cnt  (inst_cnt),
      .cycle_cnt (cycle_cnt)
   );

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: per-cycle timeline bench for npc_ctrl; instruction latencies are
// expanded into expected cycle records and replayed against the DUT.
module tb_npc_ctrl;

   localparam int CNT_W = 64;
`ifdef NPC_CTRL_TIMEOUT_EN
   localparam int TB_TO = 8;
`else
   localparam int TB_TO = 1024;
`endif

   localparam logic [2:0] S_FR = 3'd0, S_FW = 3'd1, S_DEC = 3'd2, S_MR = 3'd3,
                          S_MW = 3'd4, S_COM = 3'd5, S_HALT = 3'd6;

   typedef struct {
      logic       ireq_rdy, irsp, lreq_rdy, lrsp, is_mem, ebreak, regw;
      logic [2:0] st;
      logic       ivalid, irwe, lvalid, pcwe, rfwe, halted, commit;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             imem_req_valid, imem_req_ready, imem_rsp_valid, ir_we;
   logic             dec_regwrite, dec_is_mem, dec_is_ebreak;
   logic             lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
   logic             rf_we, pc_we, halted, err;
   logic [2:0]       state;
   logic [CNT_W-1:0] inst_cnt, cycle_cnt;

   vec_t        tl[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] exp_cyc, exp_inst;

   npc_ctrl #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TB_TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .ir_we          (ir_we),
      .dec_regwrite   (dec_regwrite),
      .dec_is_mem     (dec_is_mem),
      .dec_is_ebreak  (dec_is_ebreak),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_rsp_valid  (lsu_rsp_valid),
      .rf_we          (rf_we),
      .pc_we          (pc_we),
      .halted         (halted),
      .err            (err),
      .state          (state),
      .inst_cnt       (inst_cnt),
      .cycle_cnt      (cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      n_chk++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   function automatic logic coin();
      return ($urandom_range(0, 1) == 1);
   endfunction

   // Inputs the DUT must ignore in this phase are randomised
   function automatic vec_t blank(input logic [2:0] st, input bit fetch_ph, input bit mem_ph);
      vec_t v;
      v.ireq_rdy = !fetch_ph && coin();
      v.irsp     = !fetch_ph && coin();
      v.lreq_rdy = !mem_ph && coin();
      v.lrsp     = !mem_ph && coin();
      v.is_mem   = coin();
      v.ebreak   = coin();
      v.regw     = coin();
      v.st       = st;
      v.ivalid   = 1'b0;
      v.irwe     = 1'b0;
      v.lvalid   = 1'b0;
      v.pcwe     = 1'b0;
      v.rfwe     = 1'b0;
      v.halted   = 1'b0;
      v.commit   = 1'b0;
      return v;
   endfunction

   // a: fetch stall cycles, b: cycles from accept to word (0 = same cycle),
   // c: data stall cycles, d: cycles from data accept to completion
   task automatic add_inst(input int a, input int b, input bit mem, input int c, input int d,
                           input bit rw, input bit ebk, input int halt_cyc);
      vec_t v;
      for (int i = 0; i < a; i++) begin
         v = blank(S_FR, 1, 0); v.ivalid = 1'b1; tl.push_back(v);
      end
      v = blank(S_FR, 1, 0);
      v.ivalid = 1'b1; v.ireq_rdy = 1'b1; v.irsp = (b == 0); v.irwe = (b == 0);
      tl.push_back(v);
      if (b > 0) begin
         for (int i = 1; i < b; i++) begin
            v = blank(S_FW, 1, 0); tl.push_back(v);
         end
         v = blank(S_FW, 1, 0); v.irsp = 1'b1; v.irwe = 1'b1; tl.push_back(v);
      end
      v = blank(S_DEC, 0, 0);
      v.ebreak = ebk; v.is_mem = ebk ? 1'b1 : mem;
      tl.push_back(v);
      if (ebk) begin
         for (int i = 0; i < halt_cyc; i++) begin
            v = blank(S_HALT, 0, 0); v.halted = 1'b1; tl.push_back(v);
         end
         return;
      end
      if (mem) begin
         for (int i = 0; i < c; i++) begin
            v = blank(S_MR, 0, 1); v.lvalid = 1'b1; tl.push_back(v);
         end
         v = blank(S_MR, 0, 1);
         v.lvalid = 1'b1; v.lreq_rdy = 1'b1; v.lrsp = (d == 0);
         tl.push_back(v);
         if (d > 0) begin
            for (int i = 1; i < d; i++) begin
               v = blank(S_MW, 0, 1); tl.push_back(v);
            end
            v = blank(S_MW, 0, 1); v.lrsp = 1'b1; tl.push_back(v);
         end
      end
      v = blank(S_COM, 0, 0);
      v.regw = rw; v.pcwe = 1'b1; v.rfwe = rw; v.commit = 1'b1;
      tl.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      imem_req_ready = v.ireq_rdy;
      imem_rsp_valid = v.irsp;
      lsu_req_ready  = v.lreq_rdy;
      lsu_rsp_valid  = v.lrsp;
      dec_is_mem     = v.is_mem;
      dec_is_ebreak  = v.ebreak;
      dec_regwrite   = v.regw;
   endtask

   task automatic drive_idle();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      lsu_req_ready  = 1'b0; lsu_rsp_valid  = 1'b0;
      dec_is_mem     = 1'b0; dec_is_ebreak  = 1'b0; dec_regwrite = 1'b0;
   endtask

   // Entered and left at posedge+1
   task automatic run_tl(input string name, input int n_max);
      int n;
      n = (n_max == 0 || n_max > tl.size()) ? tl.size() : n_max;
      for (int k = 0; k < n; k++) begin
         drive(tl[k]);
         @(negedge clk);
         chk($sformatf("%s[%0d].outs", name, k),
             {state, imem_req_valid, ir_we, lsu_req_valid, pc_we, rf_we, halted, err},
             {tl[k].st, tl[k].ivalid, tl[k].irwe, tl[k].lvalid, tl[k].pcwe, tl[k].rfwe,
              tl[k].halted, 1'b0});
         chk($sformatf("%s[%0d].cnts", name, k), {inst_cnt[31:0], cycle_cnt[31:0]},
             {exp_inst[31:0], exp_cyc[31:0]});
         if (tl[k].commit) exp_inst = exp_inst + 64'd1;
         exp_cyc = exp_cyc + 64'd1;
         @(posedge clk); #1;
      end
      tl.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset.outs", {state, imem_req_valid, ir_we, lsu_req_valid, pc_we, rf_we, halted, err},
          10'd0);
      chk("reset.inst_cnt", inst_cnt, 64'd0);
      chk("reset.cycle_cnt", cycle_cnt, 64'd0);
      @(posedge clk); #1;
      rst      = 1'b0;
      exp_cyc  = 64'd0;
      exp_inst = 64'd0;
   endtask

   initial begin
      drive_idle();
      do_reset();

      // three back-to-back ALU instructions with zero-wait memories
      for (int i = 0; i < 3; i++) add_inst(0, 0, 0, 0, 0, 1, 0, 0);
      run_tl("alu3", 0);
      @(negedge clk);
      chk("alu3.inst_cnt", inst_cnt, 64'd3);
      chk("alu3.cycle_cnt", cycle_cnt, 64'd9);

      // stalled fetch, slow load, store without register write
      do_reset();
      add_inst(4, 2, 0, 0, 0, 1, 0, 0);
      add_inst(0, 0, 1, 0, 5, 1, 0, 0);
      add_inst(0, 1, 1, 2, 0, 0, 0, 0);
      run_tl("stall_ld_st", 0);
      @(negedge clk);
      chk("stall_ld_st.inst_cnt", inst_cnt, 64'd3);
      chk("stall_ld_st.cycle_cnt", cycle_cnt, 64'd25);

      // ebreak after two retired instructions, then reset out of HALT
      do_reset();
      add_inst(0, 0, 0, 0, 0, 1, 0, 0);
      add_inst(1, 0, 0, 0, 0, 0, 0, 0);
      add_inst(0, 0, 0, 0, 0, 0, 1, 10);
      run_tl("ebreak", 0);
      @(negedge clk);
      chk("ebreak.state", state, 64'd6);
      chk("ebreak.halted", halted, 64'd1);
      chk("ebreak.inst_cnt", inst_cnt, 64'd2);
      chk("ebreak.cycle_cnt", cycle_cnt, 64'd19);
      do_reset();

      // randomised instruction stream ending in ebreak
      for (int i = 0; i < 40; i++) begin
         add_inst($urandom_range(0, 3), $urandom_range(0, 3), coin(),
                  $urandom_range(0, 3), $urandom_range(0, 4), coin(), 0, 0);
      end
      add_inst($urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 0, 0, 1, 4);
      run_tl("rand", 0);

      // reset arriving while a data request is pending
      do_reset();
      add_inst(0, 0, 1, 5, 0, 1, 0, 0);
      run_tl("midhs", 4);
      rst = 1'b1;
      lsu_req_ready = 1'b1;
      lsu_rsp_valid = 1'b1;
      @(negedge clk);
      chk("midhs.gated", {imem_req_valid, ir_we, lsu_req_valid, pc_we, rf_we}, 64'd0);
      chk("midhs.state_before", state, 64'd3);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midhs.state_after", state, 64'd0);
      chk("midhs.cycle_cnt", cycle_cnt, 64'd0);
      do_reset();

      // instruction memory never ready
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
`ifdef NPC_CTRL_TIMEOUT_EN
         chk($sformatf("wdog[%0d].state", k), state, (k < TB_TO) ? 64'd0 : 64'd6);
         chk($sformatf("wdog[%0d].err", k), {err, halted}, (k < TB_TO) ? 64'd0 : 64'd3);
`endif
         @(posedge clk); #1;
      end
`ifndef NPC_CTRL_TIMEOUT_EN
      @(negedge clk);
      chk("stall100.state", state, 64'd0);
      chk("stall100.err_halted", {err, halted}, 64'd0);
      chk("stall100.req_valid", imem_req_valid, 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
